// File: rtl/map_table_ss.sv
// rtl/map_table_ss.sv - superscalar rename map table with branch checkpoints
// Optional same-cycle CDB ready bypass on lookups: MAP_TABLE_CDB_BYPASS_EN
module map_table_ss #(
  parameter int WIDTH    = 2,
  parameter int NUM_CDB  = 2,
  parameter int NUM_PR   = 64,
  parameter int PRW      = $clog2(NUM_PR),
  parameter int NUM_CKPT = 4,
  parameter int CKW      = $clog2(NUM_CKPT),
  parameter int ZERO_REG = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WIDTH-1:0]         dispatch_en,
  input  logic [WIDTH*5-1:0]       dest_idx,
  input  logic [WIDTH*5-1:0]       rega_idx,
  input  logic [WIDTH*5-1:0]       regb_idx,
  input  logic [WIDTH*PRW-1:0]     fl_T_idx,
  input  logic [WIDTH-1:0]         ckpt_req,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*PRW-1:0]   cdb_T_idx,
  input  logic                     rollback_en,
  input  logic [CKW-1:0]           rollback_id,
  input  logic                     ckpt_free_en,
  input  logic [CKW-1:0]           ckpt_free_id,
  output logic [WIDTH*PRW-1:0]     T1_idx,
  output logic [WIDTH*PRW-1:0]     T2_idx,
  output logic [WIDTH-1:0]         T1_ready,
  output logic [WIDTH-1:0]         T2_ready,
  output logic [WIDTH*PRW-1:0]     Told_idx,
  output logic [CKW-1:0]           ckpt_id,
  output logic                     ckpt_full
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [PRW-1:0]      map_idx_q [32];
  logic [PRW-1:0]      map_idx_d [32];
  logic [31:0]         map_rdy_q, map_rdy_d;
  logic [PRW-1:0]      ckpt_idx_q [NUM_CKPT][32];
  logic [PRW-1:0]      ckpt_idx_d [NUM_CKPT][32];
  logic [31:0]         ckpt_rdy_q [NUM_CKPT];
  logic [31:0]         ckpt_rdy_d [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
  // younger_q[i][j]: slot j was allocated after slot i
  logic [NUM_CKPT-1:0] younger_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] younger_d [NUM_CKPT];
  logic [NUM_CKPT-1:0] kill;

  function automatic logic cdb_hit(input logic [PRW-1:0] tag,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*PRW-1:0] t);
    logic h;
    h = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (v[c] && t[c*PRW +: PRW] == tag) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    logic found;
    ckpt_id = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (!ckpt_valid_q[i] && !found) begin
        ckpt_id = CKW'(i);
        found   = 1'b1;
      end
    end
  end
  assign ckpt_full = &ckpt_valid_q;

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    logic [4:0]     ra, rb, rd;
    logic [PRW-1:0] ta, tb, to;
    logic           fa, fb;

    assign ra = rega_idx[k*5 +: 5];
    assign rb = regb_idx[k*5 +: 5];
    assign rd = dest_idx[k*5 +: 5];

    // Older lanes in the same group override the map; the youngest match wins
    always_comb begin
      ta = map_idx_q[ra];
      tb = map_idx_q[rb];
      to = map_idx_q[rd];
      fa = 1'b0;
      fb = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (dispatch_en[j] && dest_idx[j*5 +: 5] != ZR) begin
          if (dest_idx[j*5 +: 5] == ra) begin ta = fl_T_idx[j*PRW +: PRW]; fa = 1'b1; end
          if (dest_idx[j*5 +: 5] == rb) begin tb = fl_T_idx[j*PRW +: PRW]; fb = 1'b1; end
          if (dest_idx[j*5 +: 5] == rd) to = fl_T_idx[j*PRW +: PRW];
        end
      end
    end

`ifdef MAP_TABLE_CDB_BYPASS_EN
    assign T1_ready[k] = (ra == ZR) | (!fa & (map_rdy_q[ra] | cdb_hit(ta, cdb_valid, cdb_T_idx)));
    assign T2_ready[k] = (rb == ZR) | (!fb & (map_rdy_q[rb] | cdb_hit(tb, cdb_valid, cdb_T_idx)));
`else
    assign T1_ready[k] = (ra == ZR) | (!fa & map_rdy_q[ra]);
    assign T2_ready[k] = (rb == ZR) | (!fb & map_rdy_q[rb]);
`endif
    assign T1_idx[k*PRW +: PRW]   = ta;
    assign T2_idx[k*PRW +: PRW]   = tb;
    assign Told_idx[k*PRW +: PRW] = to;
  end

  always_comb begin
    map_idx_d    = map_idx_q;
    ckpt_idx_d   = ckpt_idx_q;
    ckpt_valid_d = ckpt_valid_q;
    younger_d    = younger_q;
    kill         = '0;
    // Completion lands before any rename write or snapshot this cycle
    for (int r = 0; r < 32; r++)
      map_rdy_d[r] = map_rdy_q[r] | cdb_hit(map_idx_q[r], cdb_valid, cdb_T_idx);
    for (int c = 0; c < NUM_CKPT; c++)
      for (int r = 0; r < 32; r++)
        ckpt_rdy_d[c][r] = ckpt_rdy_q[c][r] | cdb_hit(ckpt_idx_q[c][r], cdb_valid, cdb_T_idx);

    if (rollback_en) begin
      map_idx_d       = ckpt_idx_q[rollback_id];
      map_rdy_d       = ckpt_rdy_d[rollback_id];
      kill            = younger_q[rollback_id];
      kill[rollback_id] = 1'b1;
      ckpt_valid_d    = ckpt_valid_q & ~kill;
      for (int i = 0; i < NUM_CKPT; i++)
        younger_d[i] = younger_q[i] & ~kill;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (dispatch_en[k]) begin
          if (dest_idx[k*5 +: 5] != ZR) begin
            map_idx_d[dest_idx[k*5 +: 5]] = fl_T_idx[k*PRW +: PRW];
            map_rdy_d[dest_idx[k*5 +: 5]] = 1'b0;
          end
          if (ckpt_req[k]) begin
            ckpt_idx_d[ckpt_id]   = map_idx_d;
            ckpt_rdy_d[ckpt_id]   = map_rdy_d;
            ckpt_valid_d[ckpt_id] = 1'b1;
            for (int i = 0; i < NUM_CKPT; i++)
              if (ckpt_valid_q[i]) younger_d[i][ckpt_id] = 1'b1;
            younger_d[ckpt_id] = '0;
          end
        end
      end
    end

    if (ckpt_free_en) begin
      ckpt_valid_d[ckpt_free_id] = 1'b0;
      for (int i = 0; i < NUM_CKPT; i++)
        younger_d[i][ckpt_free_id] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) map_idx_q[r] <= PRW'(r);
      map_rdy_q    <= '1;
      ckpt_valid_q <= '0;
      for (int c = 0; c < NUM_CKPT; c++) begin
        younger_q[c]  <= '0;
        ckpt_rdy_q[c] <= '0;
        for (int r = 0; r < 32; r++) ckpt_idx_q[c][r] <= '0;
      end
    end else if (en) begin
      map_idx_q    <= map_idx_d;
      map_rdy_q    <= map_rdy_d;
      ckpt_idx_q   <= ckpt_idx_d;
      ckpt_rdy_q   <= ckpt_rdy_d;
      ckpt_valid_q <= ckpt_valid_d;
      younger_q    <= younger_d;
    end
  end

endmodule

// File: tb/tb_map_table_ss.sv
// tb/tb_map_table_ss.sv - self-checking bench for map_table_ss
module tb_map_table_ss;
  localparam int WIDTH = 2, NUM_CDB = 2, NUM_PR = 64, PRW = 6, NUM_CKPT = 4, CKW = 2;
`ifdef MAP_TABLE_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset, en;
  logic [WIDTH-1:0]       dispatch_en, ckpt_req;
  logic [WIDTH*5-1:0]     dest_idx, rega_idx, regb_idx;
  logic [WIDTH*PRW-1:0]   fl_T_idx;
  logic [NUM_CDB-1:0]     cdb_valid;
  logic [NUM_CDB*PRW-1:0] cdb_T_idx;
  logic                   rollback_en, ckpt_free_en;
  logic [CKW-1:0]         rollback_id, ckpt_free_id;
  logic [WIDTH*PRW-1:0]   T1_idx, T2_idx, Told_idx;
  logic [WIDTH-1:0]       T1_ready, T2_ready;
  logic [CKW-1:0]         ckpt_id;
  logic                   ckpt_full;

  int n_checks = 0;
  int n_fail   = 0;

  map_table_ss #(.WIDTH(WIDTH), .NUM_CDB(NUM_CDB), .NUM_PR(NUM_PR), .NUM_CKPT(NUM_CKPT), .ZERO_REG(31)) dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
    .dest_idx(dest_idx), .rega_idx(rega_idx), .regb_idx(regb_idx), .fl_T_idx(fl_T_idx),
    .ckpt_req(ckpt_req), .cdb_valid(cdb_valid), .cdb_T_idx(cdb_T_idx),
    .rollback_en(rollback_en), .rollback_id(rollback_id),
    .ckpt_free_en(ckpt_free_en), .ckpt_free_id(ckpt_free_id),
    .T1_idx(T1_idx), .T2_idx(T2_idx), .T1_ready(T1_ready), .T2_ready(T2_ready),
    .Told_idx(Told_idx), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full)
  );

  always #5 clock = ~clock;

  // Reference model: architectural map, snapshot copies, checkpoints in allocation order
  int m_tag [32];
  bit m_rdy [32];
  int c_tag [NUM_CKPT][32];
  bit c_rdy [NUM_CKPT][32];
  int order [$];

  function automatic bit hit(int t);
    for (int c = 0; c < NUM_CDB; c++)
      if (cdb_valid[c] && int'(cdb_T_idx[c*PRW +: PRW]) == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_id();
    for (int i = 0; i < NUM_CKPT; i++) begin
      bit used = 1'b0;
      foreach (order[p]) if (order[p] == i) used = 1'b1;
      if (!used) return i;
    end
    return 0;
  endfunction

  function automatic void model_src(input int k, input int r, output int tag, output bit rdy);
    for (int j = k - 1; j >= 0; j--) begin
      if (dispatch_en[j] && int'(dest_idx[j*5 +: 5]) == r && r != 31) begin
        tag = int'(fl_T_idx[j*PRW +: PRW]);
        rdy = 1'b0;
        return;
      end
    end
    tag = m_tag[r];
    rdy = m_rdy[r] || (BYP && hit(tag)) || (r == 31);
  endfunction

  function automatic void model_step();
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_tag[r] = r; m_rdy[r] = 1'b1; end
      order.delete();
      return;
    end
    if (!en) return;
    for (int r = 0; r < 32; r++) if (hit(m_tag[r])) m_rdy[r] = 1'b1;
    for (int c = 0; c < NUM_CKPT; c++)
      for (int r = 0; r < 32; r++) if (hit(c_tag[c][r])) c_rdy[c][r] = 1'b1;
    if (rollback_en) begin
      int pos = 0;
      foreach (order[p]) if (order[p] == int'(rollback_id)) pos = p;
      for (int r = 0; r < 32; r++) begin
        m_tag[r] = c_tag[rollback_id][r];
        m_rdy[r] = c_rdy[rollback_id][r];
      end
      while (order.size() > pos) void'(order.pop_back());
    end else begin
      int id = exp_id();
      for (int k = 0; k < WIDTH; k++) begin
        if (!dispatch_en[k]) continue;
        if (int'(dest_idx[k*5 +: 5]) != 31) begin
          m_tag[dest_idx[k*5 +: 5]] = int'(fl_T_idx[k*PRW +: PRW]);
          m_rdy[dest_idx[k*5 +: 5]] = 1'b0;
        end
        if (ckpt_req[k]) begin
          for (int r = 0; r < 32; r++) begin c_tag[id][r] = m_tag[r]; c_rdy[id][r] = m_rdy[r]; end
          order.push_back(id);
        end
      end
    end
    if (ckpt_free_en)
      for (int p = order.size() - 1; p >= 0; p--)
        if (order[p] == int'(ckpt_free_id)) order.delete(p);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear();
    en = 1'b1; dispatch_en = '0; ckpt_req = '0;
    dest_idx = '0; rega_idx = '0; regb_idx = '0; fl_T_idx = '0;
    cdb_valid = '0; cdb_T_idx = '0;
    rollback_en = 1'b0; rollback_id = '0; ckpt_free_en = 1'b0; ckpt_free_id = '0;
  endtask

  task automatic do_reset();
    clear();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic alloc_branch();
    clear();
    dispatch_en = 2'b01; ckpt_req = 2'b01; dest_idx[4:0] = 5'd31;
    cycle();
    clear();
  endtask

  task automatic test_reset();
    do_reset();
    rega_idx = {5'd17, 5'd4}; regb_idx = {5'd31, 5'd9};
    #1;
    n_checks++; if (T1_idx !== {6'd17, 6'd4}) begin n_fail++; $display("FAIL reset_t1 got %h exp %h", T1_idx, {6'd17, 6'd4}); end
    n_checks++; if (T2_idx !== {6'd31, 6'd9}) begin n_fail++; $display("FAIL reset_t2 got %h exp %h", T2_idx, {6'd31, 6'd9}); end
    n_checks++; if ({T1_ready, T2_ready} !== 4'hf) begin n_fail++; $display("FAIL reset_ready got %b exp 1111", {T1_ready, T2_ready}); end
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b000) begin n_fail++; $display("FAIL reset_ckpt got full=%b id=%0d exp 0/0", ckpt_full, ckpt_id); end
  endtask

  task automatic test_forward();
    do_reset();
    dispatch_en = 2'b11;
    dest_idx = {5'd3, 5'd3}; fl_T_idx = {6'd41, 6'd40}; rega_idx = {5'd3, 5'd0};
    #1;
    n_checks++; if (T1_idx[11:6] !== 6'd40) begin n_fail++; $display("FAIL fwd_t1 got %0d exp 40", T1_idx[11:6]); end
    n_checks++; if (T1_ready[1] !== 1'b0) begin n_fail++; $display("FAIL fwd_rdy got %b exp 0", T1_ready[1]); end
    n_checks++; if (Told_idx !== {6'd40, 6'd3}) begin n_fail++; $display("FAIL fwd_told got %h exp %h", Told_idx, {6'd40, 6'd3}); end
    cycle();
    clear(); rega_idx[4:0] = 5'd3;
    #1;
    n_checks++; if ({T1_idx[5:0], T1_ready[0]} !== {6'd41, 1'b0}) begin n_fail++; $display("FAIL fwd_next got tag=%0d rdy=%b exp 41/0", T1_idx[5:0], T1_ready[0]); end
  endtask

  task automatic test_cdb();
    clear(); rega_idx[4:0] = 5'd3; cdb_valid = 2'b10; cdb_T_idx[11:6] = 6'd41;
    #1;
    n_checks++; if (T1_ready[0] !== BYP) begin n_fail++; $display("FAIL cdb_same got %b exp %b", T1_ready[0], BYP); end
    cycle();
    clear(); rega_idx[4:0] = 5'd3;
    #1;
    n_checks++; if (T1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL cdb_next got %b exp 1", T1_ready[0]); end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; dispatch_en = 2'b01; dest_idx[4:0] = 5'd7; fl_T_idx[5:0] = 6'd33; ckpt_req = 2'b01;
    cycle();
    clear(); rega_idx[4:0] = 5'd7;
    #1;
    n_checks++; if ({T1_idx[5:0], T1_ready[0], ckpt_id} !== {6'd7, 1'b1, 2'd0}) begin n_fail++; $display("FAIL en_hold got tag=%0d rdy=%b id=%0d exp 7/1/0", T1_idx[5:0], T1_ready[0], ckpt_id); end
  endtask

  task automatic test_rollback();
    do_reset();
    dispatch_en = 2'b11; ckpt_req = 2'b01;
    dest_idx = {5'd5, 5'd31}; fl_T_idx = {6'd50, 6'd0};
    #1;
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b000) begin n_fail++; $display("FAIL rb_alloc_id got full=%b id=%0d exp 0/0", ckpt_full, ckpt_id); end
    cycle();
    clear(); rega_idx[4:0] = 5'd5;
    #1;
    n_checks++; if ({T1_idx[5:0], T1_ready[0], ckpt_id} !== {6'd50, 1'b0, 2'd1}) begin n_fail++; $display("FAIL rb_pre got tag=%0d rdy=%b id=%0d exp 50/0/1", T1_idx[5:0], T1_ready[0], ckpt_id); end
    rollback_en = 1'b1; rollback_id = 2'd0;
    dispatch_en = 2'b01; dest_idx[4:0] = 5'd5; fl_T_idx[5:0] = 6'd55;
    cycle();
    clear(); rega_idx[4:0] = 5'd5;
    #1;
    n_checks++; if ({T1_idx[5:0], T1_ready[0]} !== {6'd5, 1'b1}) begin n_fail++; $display("FAIL rb_map got tag=%0d rdy=%b exp 5/1", T1_idx[5:0], T1_ready[0]); end
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b000) begin n_fail++; $display("FAIL rb_free got full=%b id=%0d exp 0/0", ckpt_full, ckpt_id); end
  endtask

  task automatic test_nested_rollback();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ckpt_id !== CKW'(i)) begin n_fail++; $display("FAIL nest_id%0d got %0d exp %0d", i, ckpt_id, i); end
      alloc_branch();
    end
    rollback_en = 1'b1; rollback_id = 2'd1;
    cycle();
    clear();
    #1;
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b001) begin n_fail++; $display("FAIL nest_after got full=%b id=%0d exp 0/1", ckpt_full, ckpt_id); end
    alloc_branch();
    alloc_branch();
    #1;
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b011) begin n_fail++; $display("FAIL nest_keep0 got full=%b id=%0d exp 0/3", ckpt_full, ckpt_id); end
  endtask

  task automatic test_full_free();
    do_reset();
    for (int i = 0; i < NUM_CKPT; i++) alloc_branch();
    #1;
    n_checks++; if (ckpt_full !== 1'b1) begin n_fail++; $display("FAIL full_set got %b exp 1", ckpt_full); end
    ckpt_free_en = 1'b1; ckpt_free_id = 2'd2;
    #1;
    n_checks++; if (ckpt_full !== 1'b1) begin n_fail++; $display("FAIL full_same got %b exp 1", ckpt_full); end
    cycle();
    clear();
    #1;
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b010) begin n_fail++; $display("FAIL free_next got full=%b id=%0d exp 0/2", ckpt_full, ckpt_id); end
    alloc_branch();
    do_reset();
    #1;
    n_checks++; if ({ckpt_full, ckpt_id} !== 3'b000) begin n_fail++; $display("FAIL reset_discard got full=%b id=%0d exp 0/0", ckpt_full, ckpt_id); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    dispatch_en = 2'b11; dest_idx = {5'd2, 5'd31}; fl_T_idx = {6'd20, 6'd60}; rega_idx = {5'd31, 5'd0};
    #1;
    n_checks++; if (Told_idx[5:0] !== 6'd31) begin n_fail++; $display("FAIL zero_told got %0d exp 31", Told_idx[5:0]); end
    n_checks++; if ({T1_idx[11:6], T1_ready[1]} !== {6'd31, 1'b1}) begin n_fail++; $display("FAIL zero_fwd got tag=%0d rdy=%b exp 31/1", T1_idx[11:6], T1_ready[1]); end
    cycle();
    clear(); rega_idx[4:0] = 5'd31;
    #1;
    n_checks++; if ({T1_idx[5:0], T1_ready[0]} !== {6'd31, 1'b1}) begin n_fail++; $display("FAIL zero_map got tag=%0d rdy=%b exp 31/1", T1_idx[5:0], T1_ready[0]); end
  endtask

  function automatic logic [4:0] pick_reg();
    int r = $urandom_range(9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic test_random();
    int tag;
    bit rdy;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      clear();
      reset = ($urandom_range(199) == 0);
      en = ($urandom_range(9) != 0);
      dispatch_en = WIDTH'($urandom);
      for (int k = 0; k < WIDTH; k++) begin
        dest_idx[k*5 +: 5] = pick_reg();
        rega_idx[k*5 +: 5] = pick_reg();
        regb_idx[k*5 +: 5] = pick_reg();
        fl_T_idx[k*PRW +: PRW] = PRW'($urandom_range(NUM_PR - 1));
      end
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c] = $urandom_range(1);
        cdb_T_idx[c*PRW +: PRW] = PRW'(m_tag[$urandom_range(7)]);
      end
      if (order.size() < NUM_CKPT && $urandom_range(3) == 0) ckpt_req[$urandom_range(WIDTH - 1)] = 1'b1;
      if (order.size() > 0 && $urandom_range(7) == 0) begin
        rollback_en = 1'b1; rollback_id = CKW'(order[$urandom_range(order.size() - 1)]);
      end
      if (order.size() > 0 && $urandom_range(4) == 0) begin
        ckpt_free_en = 1'b1; ckpt_free_id = CKW'(order[$urandom_range(order.size() - 1)]);
      end
      #1;
      for (int k = 0; k < WIDTH; k++) begin
        model_src(k, int'(rega_idx[k*5 +: 5]), tag, rdy);
        n_checks++; if ({T1_idx[k*PRW +: PRW], T1_ready[k]} !== {PRW'(tag), rdy}) begin n_fail++; $display("FAIL rnd_t1 n=%0d lane=%0d got %0d/%b exp %0d/%b", n, k, T1_idx[k*PRW +: PRW], T1_ready[k], tag, rdy); end
        model_src(k, int'(regb_idx[k*5 +: 5]), tag, rdy);
        n_checks++; if ({T2_idx[k*PRW +: PRW], T2_ready[k]} !== {PRW'(tag), rdy}) begin n_fail++; $display("FAIL rnd_t2 n=%0d lane=%0d got %0d/%b exp %0d/%b", n, k, T2_idx[k*PRW +: PRW], T2_ready[k], tag, rdy); end
        model_src(k, int'(dest_idx[k*5 +: 5]), tag, rdy);
        n_checks++; if (Told_idx[k*PRW +: PRW] !== PRW'(tag)) begin n_fail++; $display("FAIL rnd_told n=%0d lane=%0d got %0d exp %0d", n, k, Told_idx[k*PRW +: PRW], tag); end
      end
      n_checks++; if ({ckpt_full, ckpt_id} !== {order.size() == NUM_CKPT, CKW'(exp_id())}) begin n_fail++; $display("FAIL rnd_ckpt n=%0d got full=%b id=%0d exp %b/%0d", n, ckpt_full, ckpt_id, order.size() == NUM_CKPT, exp_id()); end
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear();
    test_reset();
    test_forward();
    test_cdb();
    test_enable();
    test_rollback();
    test_nested_rollback();
    test_full_free();
    test_zero_reg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
